// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg
// Shared constants for the register-file scoreboard: register count,
// per-register in-flight counter width, register index width, the x0
// index and the width of the pipeline in-flight counter.
package regfile_scoreboard_pkg;

    localparam int SB_NREG   = 32;
    localparam int SB_CNT_W  = 2;
    localparam int RIDX_W    = 5;
    localparam int INF_W     = 2;

    localparam logic [RIDX_W-1:0] X0 = '0;

endpackage

// File: rtl/regfile_scoreboard_sat_counter.sv
// sb_sat_counter
// W-bit saturating up/down counter. Increment and decrement in the same
// cycle cancel. An increment at all-ones or a decrement at zero holds the
// count and raises err for that cycle.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   inc, dec  count up / count down request
//   cnt       current count (registered)
//   err       combinational overflow/underflow pulse for this cycle
module sb_sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         err
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic up;
    logic dn;

    assign up  = inc & ~dec;
    assign dn  = dec & ~inc;
    assign err = (up & (cnt == CNT_MAX)) | (dn & (cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (up && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (dn && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Scoreboard beside decode: counts uncommitted writes per architectural
// register between issue (D->E) and write-back, tracks whether execute
// holds a load, and stalls decode when it reads the destination of that
// load. x0 is never tracked.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   iss_valid/rd/wen/is_load       D->E issue of one instruction
//   d_valid, d_rs1/2, d_use1/2     sources of the instruction held in decode
//   e_adv                          execute instruction moves to memory
//   ret_valid/rd/wen               write-back commit
//   sb_stall                       load-use stall for decode (combinational)
//   sb_busy                        per-register pending-write mask
//   sb_inflight                    instructions between issue and retire
//   sb_err                         sticky overflow/underflow flag
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [RIDX_W-1:0] iss_rd,
    input  logic              iss_wen,
    input  logic              iss_is_load,
    input  logic              d_valid,
    input  logic [RIDX_W-1:0] d_rs1,
    input  logic [RIDX_W-1:0] d_rs2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic              e_adv,
    input  logic              ret_valid,
    input  logic [RIDX_W-1:0] ret_rd,
    input  logic              ret_wen,
    output logic              sb_stall,
    output logic [NREG-1:0]   sb_busy,
    output logic [INF_W-1:0]  sb_inflight,
    output logic              sb_err
);

    logic [NREG-1:0]   reg_err;
    logic              inf_err;
    logic              ld_e_valid;
    logic [RIDX_W-1:0] ld_e_rd;
    logic              err;

    assign reg_err[0] = 1'b0;
    assign sb_busy[0] = 1'b0;

    // One saturating counter per tracked register; the index compare
    // excludes x0 because r starts at 1.
    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [CNT_W-1:0] cnt;
        logic             inc;
        logic             dec;

        assign inc = iss_valid & iss_wen & (iss_rd == RIDX_W'(r));
        assign dec = ret_valid & ret_wen & (ret_rd == RIDX_W'(r));

        sb_sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc),
            .dec (dec),
            .cnt (cnt),
            .err (reg_err[r])
        );

        assign sb_busy[r] = |cnt;
    end

    // Pipeline occupancy counts every issue/retire regardless of wen.
    sb_sat_counter #(.W(INF_W)) u_inflight (
        .clk (clk),
        .rst (rst),
        .inc (iss_valid),
        .dec (ret_valid),
        .cnt (sb_inflight),
        .err (inf_err)
    );

    // Execute holds a single instruction, so one entry suffices. A new
    // issue replaces whatever was leaving execute in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_e_valid <= 1'b0;
            ld_e_rd    <= X0;
        end else if (iss_valid) begin
            ld_e_valid <= iss_is_load & iss_wen & (iss_rd != X0);
            ld_e_rd    <= iss_rd;
        end else if (e_adv) begin
            ld_e_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((|reg_err) | inf_err) begin
            err <= 1'b1;
        end
    end

    assign sb_err = err;

    // ld_e_valid implies ld_e_rd != 0, so an rs of x0 never matches.
    assign sb_stall = d_valid & ld_e_valid &
                      ((d_use1 & (d_rs1 == ld_e_rd)) |
                       (d_use2 & (d_rs2 == ld_e_rd)));

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              iss_valid;
    logic [RIDX_W-1:0] iss_rd;
    logic              iss_wen;
    logic              iss_is_load;
    logic              d_valid;
    logic [RIDX_W-1:0] d_rs1;
    logic [RIDX_W-1:0] d_rs2;
    logic              d_use1;
    logic              d_use2;
    logic              e_adv;
    logic              ret_valid;
    logic [RIDX_W-1:0] ret_rd;
    logic              ret_wen;
    logic              sb_stall;
    logic [31:0]       sb_busy;
    logic [1:0]        sb_inflight;
    logic              sb_err;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .iss_wen     (iss_wen),
        .iss_is_load (iss_is_load),
        .d_valid     (d_valid),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .d_use1      (d_use1),
        .d_use2      (d_use2),
        .e_adv       (e_adv),
        .ret_valid   (ret_valid),
        .ret_rd      (ret_rd),
        .ret_wen     (ret_wen),
        .sb_stall    (sb_stall),
        .sb_busy     (sb_busy),
        .sb_inflight (sb_inflight),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        iss_valid = 1'b1; iss_rd = rd; iss_wen = 1'b1; iss_is_load = ld;
    endtask

    task automatic retire(input logic [4:0] rd);
        ret_valid = 1'b1; ret_rd = rd; ret_wen = 1'b1;
    endtask

    task automatic idle_ctl();
        iss_valid = 1'b0; iss_wen = 1'b0; iss_is_load = 1'b0; iss_rd = 5'd0;
        ret_valid = 1'b0; ret_wen = 1'b0; ret_rd = 5'd0;
        e_adv = 1'b0;
    endtask

    initial begin
        // reset held while issue is driven
        rst = 1'b1;
        idle_ctl();
        d_valid = 1'b1; d_rs1 = 5'd4; d_rs2 = 5'd0; d_use1 = 1'b1; d_use2 = 1'b0;
        issue(5'd4, 1'b1);
        #1;
        chk("rst_busy0", sb_busy, 32'h0);
        chk("rst_stall0", {31'd0, sb_stall}, 32'd0);
        tick(); tick();
        chk("rst_busy", sb_busy, 32'h0);
        chk("rst_inflight", {30'd0, sb_inflight}, 32'd0);
        chk("rst_stall", {31'd0, sb_stall}, 32'd0);
        chk("rst_err", {31'd0, sb_err}, 32'd0);

        // release, idle
        rst = 1'b0;
        idle_ctl();
        d_valid = 1'b0;
        tick(); tick();
        chk("idle_busy", sb_busy, 32'h0);
        chk("idle_inflight", {30'd0, sb_inflight}, 32'd0);
        chk("idle_stall", {31'd0, sb_stall}, 32'd0);

        // load-use on rs1
        issue(5'd5, 1'b1);
        tick();
        idle_ctl();
        d_valid = 1'b1; d_rs1 = 5'd5; d_use1 = 1'b1; d_rs2 = 5'd0; d_use2 = 1'b0;
        #1;
        chk("lu_stall", {31'd0, sb_stall}, 32'd1);
        chk("lu_busy", sb_busy, 32'h0000_0020);
        chk("lu_inflight", {30'd0, sb_inflight}, 32'd1);
        e_adv = 1'b1;
        tick();
        e_adv = 1'b0;
        #1;
        chk("lu_stall_drop", {31'd0, sb_stall}, 32'd0);
        retire(5'd5);
        tick();
        idle_ctl();
        chk("lu_ret_busy", sb_busy, 32'h0);
        chk("lu_ret_inflight", {30'd0, sb_inflight}, 32'd0);

        // non-load producer never stalls
        d_valid = 1'b0;
        issue(5'd5, 1'b0);
        tick();
        idle_ctl();
        d_valid = 1'b1; d_rs1 = 5'd0; d_use1 = 1'b0; d_rs2 = 5'd5; d_use2 = 1'b1;
        #1;
        chk("alu_stall", {31'd0, sb_stall}, 32'd0);
        chk("alu_busy5", {31'd0, sb_busy[5]}, 32'd1);
        retire(5'd5);
        tick();
        idle_ctl();
        d_valid = 1'b0;

        // load rd=6 via rs2, then issue+e_adv together replaces entry with rd=9
        issue(5'd6, 1'b1);
        tick();
        idle_ctl();
        d_valid = 1'b1; d_rs1 = 5'd0; d_use1 = 1'b1; d_rs2 = 5'd6; d_use2 = 1'b1;
        #1;
        chk("lu2_stall", {31'd0, sb_stall}, 32'd1);
        issue(5'd9, 1'b1);
        e_adv = 1'b1;
        tick();
        idle_ctl();
        #1;
        chk("ovr_old_rd", {31'd0, sb_stall}, 32'd0);
        d_rs1 = 5'd9;
        #1;
        chk("ovr_new_rd", {31'd0, sb_stall}, 32'd1);
        chk("ovr_busy", sb_busy, 32'h0000_0240);
        chk("ovr_inflight", {30'd0, sb_inflight}, 32'd2);
        e_adv = 1'b1;
        tick();
        e_adv = 1'b0;
        #1;
        chk("ovr_drop", {31'd0, sb_stall}, 32'd0);
        retire(5'd6);
        tick();
        retire(5'd9);
        tick();
        idle_ctl();
        d_valid = 1'b0;
        chk("ovr_busy_clear", sb_busy, 32'h0);
        chk("ovr_inf_clear", {30'd0, sb_inflight}, 32'd0);

        // same-cycle issue and retire on rd=7
        issue(5'd7, 1'b0);
        tick();
        issue(5'd7, 1'b0);
        retire(5'd7);
        tick();
        idle_ctl();
        chk("same_busy", sb_busy, 32'h0000_0080);
        chk("same_inflight", {30'd0, sb_inflight}, 32'd1);
        chk("same_err", {31'd0, sb_err}, 32'd0);
        retire(5'd7);
        tick();
        idle_ctl();
        chk("same_ret_busy", sb_busy, 32'h0);

        // rd=0 is never tracked
        for (int i = 0; i < 3; i++) begin
            issue(5'd0, 1'b1);
            tick();
        end
        idle_ctl();
        chk("x0_busy", sb_busy, 32'h0);
        chk("x0_err", {31'd0, sb_err}, 32'd0);
        chk("x0_inflight", {30'd0, sb_inflight}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            retire(5'd0);
            tick();
        end
        idle_ctl();
        chk("x0_inf_back", {30'd0, sb_inflight}, 32'd0);
        chk("x0_err2", {31'd0, sb_err}, 32'd0);

        // overflow on rd=3
        for (int i = 0; i < 3; i++) begin
            issue(5'd3, 1'b0);
            tick();
        end
        idle_ctl();
        chk("ov_err_pre", {31'd0, sb_err}, 32'd0);
        chk("ov_busy3", sb_busy, 32'h0000_0008);
        issue(5'd3, 1'b0);
        tick();
        idle_ctl();
        chk("ov_err", {31'd0, sb_err}, 32'd1);
        chk("ov_inflight_hold", {30'd0, sb_inflight}, 32'd3);
        retire(5'd3);
        tick();
        retire(5'd3);
        tick();
        idle_ctl();
        chk("ov_held3", {31'd0, sb_busy[3]}, 32'd1);
        retire(5'd3);
        tick();
        idle_ctl();
        chk("ov_drained", sb_busy, 32'h0);
        chk("ov_err_sticky", {31'd0, sb_err}, 32'd1);

        // reset mid-flight, between clock edges
        issue(5'd10, 1'b0);
        tick();
        issue(5'd11, 1'b0);
        tick();
        issue(5'd12, 1'b1);
        tick();
        idle_ctl();
        d_valid = 1'b1; d_rs1 = 5'd12; d_use1 = 1'b1; d_rs2 = 5'd0; d_use2 = 1'b0;
        #1;
        chk("mid_pre_stall", {31'd0, sb_stall}, 32'd1);
        chk("mid_pre_inflight", {30'd0, sb_inflight}, 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_stall", {31'd0, sb_stall}, 32'd0);
        chk("mid_busy", sb_busy, 32'h0);
        chk("mid_inflight", {30'd0, sb_inflight}, 32'd0);
        chk("mid_err", {31'd0, sb_err}, 32'd0);
        #1;
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
